// File: rtl/mult_sequencer.sv
// Sequential 32x32 unsigned shift-and-add multiplier with HI/LO result registers.
// Holds the pipeline through stall until the product is written, then pulses done.
module mult_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mult_enable,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sfmux_high,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_r;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;
  logic [63:0] acc_r;
  logic [4:0]  cnt_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [63:0] acc_next_s;

  // Conditional partial-product add; carry out of bit 63 is dropped.
  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Sequencer state, datapath and HI/LO result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mcand_r  <= 64'd0;
      mplier_r <= 32'd0;
      acc_r    <= 64'd0;
      cnt_r    <= 5'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mult_enable) begin
            mcand_r  <= {32'd0, a};
            mplier_r <= b;
            acc_r    <= 64'd0;
            cnt_r    <= 5'd0;
            state_r  <= RUN;
          end
        end
        RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + 5'd1;
          // The final add is folded in here so HI/LO see the complete product.
          if (cnt_r == 5'd31) begin
            hi_r    <= acc_next_s[63:32];
            lo_r    <= acc_next_s[31:0];
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Status decode and read mux; stall is gated by rst_n so it stays low under reset.
  always_comb begin
    busy    = (state_r == RUN);
    done    = (state_r == DONE);
    stall   = rst_n & (((state_r == IDLE) & mult_enable) | (state_r == RUN));
    if (sfmux_high) begin
      rd_data = hi_r;
    end else begin
      rd_data = lo_r;
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer: latency, results, mid-run
// operand changes, DONE behaviour and reset during RUN.
module tb_mult_sequencer;

  logic        clk;
  logic        rst_n;
  logic        mult_enable;
  logic [31:0] a;
  logic [31:0] b;
  logic        sfmux_high;
  logic [31:0] rd_data;
  logic        stall;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  mult_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mult_enable (mult_enable),
    .a           (a),
    .b           (b),
    .sfmux_high  (sfmux_high),
    .rd_data     (rd_data),
    .stall       (stall),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    sfmux_high = 1'b1;
    #1;
    check({tag, "_hi"}, {32'd0, rd_data}, {32'd0, exp_hi});
    sfmux_high = 1'b0;
    #1;
    check({tag, "_lo"}, {32'd0, rd_data}, {32'd0, exp_lo});
  endtask

  // Starts a multiply at a negedge, holds mult_enable until stall falls and
  // checks latency and result. Returns inside the DONE cycle.
  task automatic do_mult(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                         input bit mid_change, input bit keep_en);
    int stall_cycles;
    int run_cycles;
    int done_cycle;
    stall_cycles = 0;
    run_cycles   = 0;
    done_cycle   = -1;
    @(negedge clk);
    a = av;
    b = bv;
    mult_enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done && done_cycle < 0) done_cycle = i;
      if (busy) run_cycles++;
      if (stall) stall_cycles++;
      else break;
      if (mid_change && i == 5) begin
        read_hilo({tag, "_midrun"}, prev_hi, prev_lo);
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
      end
      @(negedge clk);
    end
    if (!keep_en) mult_enable = 1'b0;
    check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'd33);
    check({tag, "_run_cycles"},   64'(run_cycles),   64'd32);
    check({tag, "_done_cycle"},   64'(done_cycle),   64'd33);
    read_hilo(tag, exp_hi, exp_lo);
  endtask

  initial begin
    rst_n       = 1'b0;
    mult_enable = 1'b1;
    a           = 32'd3;
    b           = 32'd5;
    sfmux_high  = 1'b0;
    #12;
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_busy",  {63'd0, busy},  64'd0);
    check("rst_done",  {63'd0, done},  64'd0);
    read_hilo("rst", 32'd0, 32'd0);
    @(negedge clk);
    mult_enable = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_busy", {63'd0, busy}, 64'd0);

    do_mult("m3x5", 32'd3, 32'd5, 32'd0, 32'h0000_000F, 32'd0, 32'd0, 1'b0, 1'b0);
    do_mult("mmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
            32'd0, 32'd0, 1'b0, 1'b0);
    do_mult("mchg", 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800,
            32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
    do_mult("mzero", 32'h1234_5678, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // mult_enable held through DONE: no restart in DONE, restart from IDLE.
    do_mult("m2x3", 32'd2, 32'd3, 32'd0, 32'd6, 32'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("after_done_busy",  {63'd0, busy},  64'd0);
    check("after_done_done",  {63'd0, done},  64'd0);
    check("after_done_stall", {63'd0, stall}, 64'd1);
    @(negedge clk);
    #1;
    check("restart_busy", {63'd0, busy}, 64'd1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        #1;
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      check("restart_done_seen", {63'd0, seen}, 64'd1);
    end
    mult_enable = 1'b0;
    read_hilo("restart", 32'd0, 32'd6);

    // Reset pulse at RUN cycle 10 of 7*9.
    @(negedge clk);
    a = 32'd7;
    b = 32'd9;
    mult_enable = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  {63'd0, busy},  64'd0);
    check("mid_rst_stall", {63'd0, stall}, 64'd0);
    check("mid_rst_done",  {63'd0, done},  64'd0);
    read_hilo("mid_rst", 32'd0, 32'd0);
    @(negedge clk);
    mult_enable = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    do_mult("m7x9", 32'd7, 32'd9, 32'd0, 32'h0000_003F, 32'd0, 32'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
